fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the 16-bit CPU. It owns the program counter and issues word-addressed reads to the instruction memory over a valid/ready request channel. Returned instructions are buffered, together with their PC, in a small FIFO and presented to decode over a valid/ready handshake. Decode or execute can redirect the fetch stream on a jump or taken branch; the block flushes stale instructions, including any read still in flight.

## Interface
Parameters:
- DEPTH, 2: instruction FIFO entries (power of two, ≥2)
- RESET_PC, 16'h0000: PC loaded on reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset; sampled on rising edge of clk
- imem_req_valid  out  1  fetch request present
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  16  word address of request (= fetch_pc)
- imem_resp_valid  in  1  response data valid; exactly one per accepted request, in order, ≥1 cycle after acceptance
- imem_resp_data  in  16  returned instruction
- inst_valid  out  1  FIFO head holds an instruction
- inst_ready  in  1  decode consumes head this cycle
- inst  out  16  head instruction
- inst_pc  out  16  PC of head instruction
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  16  new fetch address
- halt  in  1  suppress new requests; FIFO drain and outstanding read continue

## Operation
- Registers: fetch_pc[15:0], state, FIFO (DEPTH × {pc, inst}), count, head/tail pointers.
- States:
  - IDLE: no read outstanding.
  - WAIT: read outstanding; its response is wanted.
  - DROP: read outstanding; its response is stale.
- At most one outstanding request. Requests issue only from IDLE.
- imem_req_valid = (state==IDLE) && !halt && !rst && (count < DEPTH).
  - Credit rule: the FIFO always has room for the response.
- Request handshake (req_valid && req_ready):
  - Without redirect: fetch_pc <= fetch_pc+1, modulo 2^16 (16'hFFFF wraps to 16'h0000). Go to WAIT, remembering the issued address as req_pc.
  - With redirect the same cycle: go to DROP.
- WAIT && resp_valid && !redirect: push {req_pc, resp_data}; go to IDLE.
- DROP && resp_valid: discard data; go to IDLE.
- resp_valid in IDLE: ignored, no state change.
- Redirect, highest priority:
  - FIFO is emptied (count <= 0); a simultaneous pop is absorbed.
  - fetch_pc <= redirect_pc.
  - WAIT without resp_valid goes to DROP; WAIT with resp_valid goes to IDLE and the data is dropped.
  - DROP stays DROP unless resp_valid, then goes to IDLE.
- Pop: inst_valid && inst_ready && !redirect advances the head. Push and pop in the same cycle keep count unchanged.
- inst_valid = (count != 0). inst and inst_pc come from the head entry; the values are don't-care when inst_valid = 0.
- halt only gates new requests. It never discards data.
- Outputs are stable while inst_valid && !inst_ready, absent redirect.

## Timing
- Reset values: fetch_pc=RESET_PC, state=IDLE, count=0, imem_req_valid=0, inst_valid=0. The FIFO data is don't-care.
- First cycle after rst deasserts: imem_req_valid=1, imem_req_addr=RESET_PC.
- Reset mid-operation forces IDLE and an empty FIFO. The memory shares rst, so no response is pending after reset.
- Latency: request accepted at cycle N, response at N+L (L ≥ 1) → inst_valid at N+L+1. Next request is issued at N+L+1.
- Peak throughput with L=1: one instruction per 2 cycles.
- A redirect asserted at cycle N:
  - inst_valid=0 at N+1.
  - imem_req_addr=redirect_pc at N+1 if no read is outstanding.
  - Otherwise the request issues the cycle after the stale response is dropped.
- Combinational paths: imem_req_valid depends on halt and rst. No path exists from inst_ready to imem_req_valid.

## Test plan
- Reset then 1-cycle memory returning mem[a]=16'hA000+a, inst_ready=1:
  - Required: inst_pc sequence 0,1,2,3 with inst 16'hA000..16'hA003.
  - Required: inst_valid first high 3 cycles after rst falls.
- Backpressure: inst_ready=0, DEPTH=2 → exactly 2 requests (addr 0,1), then req_valid=0. Raise inst_ready → requests resume at addr 2, no instruction lost or duplicated.
- Redirect to 16'h0040 while in WAIT with L=3:
  - Required: stale response discarded, FIFO empty next cycle.
  - Required: next request addr 16'h0040; first delivered inst_pc=16'h0040.
- Redirect coincident with resp_valid, and separately with a request handshake:
  - Required: neither the response nor the address is ever delivered.
  - Required: fetch resumes at redirect_pc.
- Wrap: redirect_pc=16'hFFFF → delivered inst_pc sequence 16'hFFFF, 16'h0000, 16'h0001.
- halt=1 mid-stream: outstanding read completes and the FIFO drains, no new request. halt=0 → next request at the following sequential PC. Also assert rst with a full FIFO → inst_valid=0 and req_addr=RESET_PC after reset.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word read at a time and
// buffers {pc, inst} pairs in a small FIFO for decode; redirect flushes the stream.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [15:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [1:0]  dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    r_state;
  logic [15:0]   r_fetch_pc;
  logic [15:0]   r_req_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [31:0]   r_mem [DEPTH];

  logic       w_req_fire;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_state_nxt;

  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid never depends on the same-side ready.
  // Requests issue only when the FIFO can absorb the response (credit rule).
  assign imem_req_valid = (r_state == S_IDLE) && !halt && !rst && (r_count < FULL);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign inst_valid = (r_count != '0);
  assign inst       = r_mem[r_head][15:0];
  assign inst_pc    = r_mem[r_head][31:16];
  assign dbg_state  = r_state;

  assign w_push = (r_state == S_WAIT) && imem_resp_valid && !redirect;
  assign w_pop  = inst_valid && inst_ready && !redirect;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req_fire) w_state_nxt = redirect ? S_DROP : S_WAIT;
      // A redirect while waiting turns the outstanding read stale.
      S_WAIT: begin
        if (imem_resp_valid) w_state_nxt = S_IDLE;
        else if (redirect)   w_state_nxt = S_DROP;
      end
      S_DROP: if (imem_resp_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect)        r_fetch_pc <= redirect_pc;
      else if (w_req_fire) r_fetch_pc <= r_fetch_pc + 16'd1;
      if (w_req_fire) r_req_pc <= r_fetch_pc;
      if (redirect) begin
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PW'(1);
        if (w_pop)  r_head <= r_head + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= {r_req_pc, imem_resp_data};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked against
// a stream-level model (expected next fetch address and next delivered PC).
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_DROP  = 2'd2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [15:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [1:0]  dbg_state;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model / scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mem_pending = 0;
  int          mem_cnt = 0;
  logic [15:0] mem_addr = '0;
  int          mem_lat = 1;
  bit          rand_lat = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] req_q[$];

  logic        obs_req_valid, obs_hs, obs_inst_valid, obs_pop, obs_resp;
  logic [15:0] obs_addr, obs_inst, obs_pc;
  logic [1:0]  obs_state;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  function automatic logic [31:0] entry(input logic [15:0] pc);
    return {pc, mem_fn(pc)};
  endfunction

  // One clock cycle: called at negedge with inputs set; the memory answers
  // L cycles after acceptance, outputs are sampled mid-cycle.
  task automatic step();
    imem_resp_valid = mem_pending && (mem_cnt == 0) && !rst;
    imem_resp_data  = imem_resp_valid ? mem_fn(mem_addr) : 16'($urandom);
    #1;
    obs_req_valid  = imem_req_valid;
    obs_addr       = imem_req_addr;
    obs_hs         = imem_req_valid && imem_req_ready;
    obs_inst_valid = inst_valid;
    obs_inst       = inst;
    obs_pc         = inst_pc;
    obs_pop        = inst_valid && inst_ready && !redirect;
    obs_resp       = imem_resp_valid;
    obs_state      = dbg_state;
    if (obs_pop) got_q.push_back({inst_pc, inst});
    if (obs_hs)  req_q.push_back(imem_req_addr);
    @(posedge clk);
    if (rst) begin
      mem_pending = 0;
    end else begin
      if (obs_resp) mem_pending = 0;
      else if (mem_pending) mem_cnt--;
      if (obs_hs) begin
        mem_pending = 1;
        mem_addr    = obs_addr;
        mem_cnt     = (rand_lat ? int'($urandom_range(1, 4)) : mem_lat) - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; redirect = 0; redirect_pc = '0; halt = 0;
    inst_ready = 0; imem_req_ready = 1; rand_lat = 0;
    step(); step();
    rst = 0;
    got_q.delete(); req_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; redirect = 0; redirect_pc = '0; halt = 0;
    inst_ready = 1; imem_req_ready = 1;
    step(); step();
    n_checks++;
    if (obs_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b expected 0", obs_req_valid); end
    n_checks++;
    if (obs_inst_valid !== 1'b0) begin n_errors++; $display("FAIL reset_inst_valid: got %b expected 0", obs_inst_valid); end
    n_checks++;
    if (obs_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", obs_state, ST_IDLE); end
    rst = 0;
    got_q.delete(); req_q.delete();
    step();
    n_checks++;
    if (obs_req_valid !== 1'b1 || obs_addr !== RESET_PC)
      begin n_errors++; $display("FAIL first_req: got valid=%b addr=%h expected valid=1 addr=%h", obs_req_valid, obs_addr, RESET_PC); end
  endtask

  task automatic test_sequential();
    int first = -1;
    do_reset();
    mem_lat = 1; inst_ready = 1;
    for (int t = 1; t <= 40 && got_q.size() < 4; t++) begin
      step();
      if (obs_inst_valid && first < 0) first = t;
    end
    n_checks++;
    if (first != 3) begin n_errors++; $display("FAIL first_inst_valid_cycle: got %0d expected 3", first); end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(entry(16'(i)));
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        begin n_errors++; $display("FAIL seq_entry[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_lat = 1; inst_ready = 0;
    for (int t = 0; t < 12; t++) step();
    n_checks++;
    if (req_q.size() != 2 || req_q[0] !== 16'h0000 || req_q[1] !== 16'h0001)
      begin n_errors++; $display("FAIL bp_requests: got %0d reqs expected 2 (addr 0,1)", req_q.size()); end
    n_checks++;
    if (obs_req_valid !== 1'b0 || obs_inst_valid !== 1'b1 || got_q.size() != 0)
      begin n_errors++; $display("FAIL bp_stall: got req_valid=%b inst_valid=%b popped=%0d expected 0,1,0", obs_req_valid, obs_inst_valid, got_q.size()); end
    inst_ready = 1;
    for (int t = 0; t < 40 && got_q.size() < 4; t++) step();
    n_checks++;
    if (req_q.size() < 3 || req_q[2] !== 16'h0002)
      begin n_errors++; $display("FAIL bp_resume_addr: got %h expected 0002", (req_q.size() > 2) ? req_q[2] : 'x); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== entry(16'(i)))
        begin n_errors++; $display("FAIL bp_entry[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 'x, entry(16'(i))); end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat = 3; inst_ready = 0;
    for (int t = 0; t < 40 && req_q.size() < 2; t++) step();
    redirect = 1; redirect_pc = 16'h0040;
    step();
    redirect = 0; inst_ready = 1;
    step();
    n_checks++;
    if (obs_inst_valid !== 1'b0) begin n_errors++; $display("FAIL rw_flush: got inst_valid=%b expected 0", obs_inst_valid); end
    n_checks++;
    if (obs_state !== ST_DROP) begin n_errors++; $display("FAIL rw_state: got %0d expected %0d", obs_state, ST_DROP); end
    for (int t = 0; t < 60 && got_q.size() < 2; t++) step();
    n_checks++;
    if (req_q.size() < 3 || req_q[2] !== 16'h0040)
      begin n_errors++; $display("FAIL rw_next_req: got %h expected 0040", (req_q.size() > 2) ? req_q[2] : 'x); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== entry(16'h0040 + 16'(i)))
        begin n_errors++; $display("FAIL rw_entry[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 'x, entry(16'h0040 + 16'(i))); end
    end
  endtask

  task automatic test_redirect_coincident();
    int k;
    int t;
    do_reset();
    mem_lat = 2; inst_ready = 1;
    for (t = 0; t < 40 && got_q.size() < 2; t++) step();
    for (t = 0; t < 20 && !(mem_pending && mem_cnt == 0); t++) step();
    n_checks++;
    if (!(mem_pending && mem_cnt == 0)) begin n_errors++; $display("FAIL rc_find_resp: got timeout expected a pending response"); end
    k = got_q.size();
    redirect = 1; redirect_pc = 16'h0100;
    step();
    redirect = 0;
    for (t = 0; t < 60 && got_q.size() < k + 2; t++) step();
    exp_q.delete();
    for (int i = 0; i < k; i++) exp_q.push_back(entry(16'(i)));
    exp_q.push_back(entry(16'h0100));
    exp_q.push_back(entry(16'h0101));
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        begin n_errors++; $display("FAIL rc_resp_entry[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); end
    end
    // now coincide with a request handshake
    for (t = 0; t < 20 && !imem_req_valid; t++) step();
    k = got_q.size();
    redirect = 1; redirect_pc = 16'h0200;
    step();
    redirect = 0;
    n_checks++;
    if (obs_hs !== 1'b1) begin n_errors++; $display("FAIL rc_req_hs: got hs=%b expected 1", obs_hs); end
    for (t = 0; t < 60 && got_q.size() < k + 2; t++) step();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (k + i >= got_q.size() || got_q[k+i] !== entry(16'h0200 + 16'(i)))
        begin n_errors++; $display("FAIL rc_req_entry[%0d]: got %h expected %h", i, (k + i < got_q.size()) ? got_q[k+i] : 'x, entry(16'h0200 + 16'(i))); end
    end
  endtask

  task automatic test_wrap();
    int k;
    do_reset();
    mem_lat = 1; inst_ready = 1;
    step(); step();
    redirect = 1; redirect_pc = 16'hFFFF;
    step();
    redirect = 0;
    k = got_q.size();
    for (int t = 0; t < 60 && got_q.size() < k + 3; t++) step();
    exp_q.delete();
    exp_q.push_back(entry(16'hFFFF));
    exp_q.push_back(entry(16'h0000));
    exp_q.push_back(entry(16'h0001));
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (k + i >= got_q.size() || got_q[k+i] !== exp_q[i])
        begin n_errors++; $display("FAIL wrap_entry[%0d]: got %h expected %h", i, (k + i < got_q.size()) ? got_q[k+i] : 'x, exp_q[i]); end
    end
  endtask

  task automatic test_halt_and_reset();
    int nreq;
    int k;
    logic [15:0] pend;
    do_reset();
    mem_lat = 2; inst_ready = 1;
    for (int t = 0; t < 40 && !(got_q.size() >= 2 && mem_pending); t++) step();
    halt = 1;
    nreq = req_q.size();
    k = got_q.size();
    pend = mem_addr;
    for (int t = 0; t < 10; t++) step();
    n_checks++;
    if (req_q.size() != nreq) begin n_errors++; $display("FAIL halt_no_req: got %0d reqs expected %0d", req_q.size(), nreq); end
    n_checks++;
    if (got_q.size() != k + 1 || got_q[$] !== entry(pend))
      begin n_errors++; $display("FAIL halt_drain: got %0d delivered last %h expected %0d last %h", got_q.size(), got_q[$], k + 1, entry(pend)); end
    n_checks++;
    if (obs_inst_valid !== 1'b0) begin n_errors++; $display("FAIL halt_empty: got inst_valid=%b expected 0", obs_inst_valid); end
    halt = 0;
    for (int t = 0; t < 10 && req_q.size() <= nreq; t++) step();
    n_checks++;
    if (req_q.size() <= nreq || req_q[nreq] !== pend + 16'd1)
      begin n_errors++; $display("FAIL halt_resume: got %h expected %h", (req_q.size() > nreq) ? req_q[nreq] : 'x, pend + 16'd1); end
    inst_ready = 0;
    for (int t = 0; t < 12; t++) step();
    n_checks++;
    if (obs_inst_valid !== 1'b1 || obs_req_valid !== 1'b0)
      begin n_errors++; $display("FAIL full_before_reset: got inst_valid=%b req_valid=%b expected 1,0", obs_inst_valid, obs_req_valid); end
    rst = 1;
    step();
    rst = 0;
    step();
    n_checks++;
    if (obs_inst_valid !== 1'b0 || obs_req_valid !== 1'b1 || obs_addr !== RESET_PC)
      begin n_errors++; $display("FAIL reset_mid_op: got inst_valid=%b req_valid=%b addr=%h expected 0,1,%h", obs_inst_valid, obs_req_valid, obs_addr, RESET_PC); end
  endtask

  task automatic test_random();
    logic [15:0] model_fetch;
    logic [15:0] model_del;
    bit          pend_before;
    bit          prev_hold = 0;
    logic [15:0] prev_pc = '0;
    logic [15:0] prev_inst = '0;
    int          n_pops = 0;
    do_reset();
    rand_lat = 1;
    model_fetch = RESET_PC;
    model_del   = RESET_PC;
    for (int t = 0; t < 3000; t++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect       = ($urandom_range(0, 29) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      pend_before = mem_pending;
      step();
      if (obs_hs) begin
        n_checks++;
        if (obs_addr !== model_fetch || pend_before)
          begin n_errors++; $display("FAIL rnd_req t=%0d: got addr=%h overlap=%b expected addr=%h overlap=0", t, obs_addr, pend_before, model_fetch); end
      end
      if (halt) begin
        n_checks++;
        if (obs_req_valid !== 1'b0) begin n_errors++; $display("FAIL rnd_halt t=%0d: got req_valid=%b expected 0", t, obs_req_valid); end
      end
      if (obs_pop) begin
        n_checks++;
        n_pops++;
        if (got_q[$] !== entry(model_del))
          begin n_errors++; $display("FAIL rnd_deliver t=%0d: got %h expected %h", t, got_q[$], entry(model_del)); end
        model_del = model_del + 16'd1;
      end
      if (prev_hold) begin
        n_checks++;
        if (obs_inst_valid !== 1'b1 || obs_pc !== prev_pc || obs_inst !== prev_inst)
          begin n_errors++; $display("FAIL rnd_stable t=%0d: got %b %h %h expected 1 %h %h", t, obs_inst_valid, obs_pc, obs_inst, prev_pc, prev_inst); end
      end
      if (redirect) begin
        model_fetch = redirect_pc;
        model_del   = redirect_pc;
      end else if (obs_hs) begin
        model_fetch = model_fetch + 16'd1;
      end
      prev_hold = obs_inst_valid && !inst_ready && !redirect;
      prev_pc   = obs_pc;
      prev_inst = obs_inst;
    end
    redirect = 0; halt = 0; rand_lat = 0;
    n_checks++;
    if (n_pops < 100) begin n_errors++; $display("FAIL rnd_activity: got %0d deliveries expected >= 100", n_pops); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1; redirect = 0; redirect_pc = '0; halt = 0;
    inst_ready = 0; imem_req_ready = 0;
    imem_resp_valid = 0; imem_resp_data = '0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_wrap();
    test_halt_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
